dff_serial_tx: RTL and testbench
================================

Name: dff_serial_tx

Overview:
- Parallel-in, serial-out transmitter that drives the data and clock inputs of a downstream D-flip-flop shift chain.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per bit period.
- Generates its own bit clock, with the rising edge at mid-bit, so a receiving D flip-flop on that clock samples stable data.
- Provides frame and done indications for LED display and sequencing.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- DIV, 2, system clock cycles per bit period; must be even and ≥2.
- LSB_FIRST, 0, bit order: 0 sends bit WIDTH-1 first, 1 sends bit 0 first.

Ports:
- input_clock1_1  input  1  system clock; all logic on rising edge.
- input_reset_2  input  1  synchronous, active-high reset.
- input_load_valid_3  input  1  a word is offered on input_load_data_4.
- input_load_data_4  input  WIDTH  word to transmit.
- output_load_ready_5  output  1  block can accept a word (combinational: state==IDLE).
- output_serial_data_6  output  1  serial data line to the receiver's D input.
- output_serial_clock_7  output  1  bit clock to the receiver's clock input.
- output_frame_8  output  1  high while bits are being driven.
- output_done_9  output  1  one-cycle pulse after the last bit period.

Behaviour:
- Reset is synchronous, active-high, and applies on the clock edge where input_reset_2 is high. After that edge:
  - state=IDLE, serial_data=0, serial_clock=0, frame=0, done=0;
  - shift register, bit counter and divider counter are 0;
  - load_ready=1.
- Reset asserted mid-frame aborts the frame at that edge. The partial word is discarded and no done pulse is issued.
- All outputs except load_ready are registered.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - load_ready=1.
  - If load_valid=1 at edge k: capture load_data into the shift register, set bit_cnt=WIDTH-1 and div_cnt=0, and go to SHIFT.
  - load_valid=0 keeps the FSM in IDLE.
- SHIFT, from cycle k+1:
  - frame=1 and load_ready=0.
  - serial_data = current head bit (MSB, or LSB if LSB_FIRST=1), held constant for DIV cycles.
  - serial_clock=0 for div_cnt in 0..DIV/2-1 and 1 for div_cnt in DIV/2..DIV-1, giving exactly one rising edge per bit, mid-period.
  - div_cnt increments each cycle and wraps from DIV-1 to 0.
  - On wrap with bit_cnt>0: shift the register one position toward the head and decrement bit_cnt.
  - On wrap with bit_cnt==0: go to DONE.
- DONE:
  - Lasts exactly one cycle: done=1, frame=0, serial_clock=0, serial_data=0, load_ready=0.
  - Next state is IDLE.
- Timing for a load accepted at edge k:
  - frame high for cycles k+1 .. k+WIDTH*DIV;
  - done high in cycle k+WIDTH*DIV+1;
  - load_ready high again in cycle k+WIDTH*DIV+2;
  - minimum word-to-word spacing is WIDTH*DIV+2 cycles.
- load_valid is ignored while load_ready=0. No capture occurs and no error is raised. The upstream source must hold the word until it is accepted.
- Changes on load_data outside the accept edge have no effect on a frame in progress.
- The serial_clock rising edge always falls on a cycle where serial_data has been stable for at least DIV/2 cycles. No glitch is allowed: serial_clock is a register output, never combinational.
- Over a full frame the receiver sees exactly WIDTH rising edges on serial_clock.
- Reset and load_valid in the same cycle: reset wins and nothing is captured.

Test Plan:
- Reset check: hold reset 2 cycles then release. Required: load_ready=1 and data/clock/frame/done=0; held with load_valid=0 for 10 cycles.
- MSB-first word (WIDTH=8, DIV=2, LSB_FIRST=0): load 0xA5 at edge k.
  - serial_data sequence is 1,0,1,0,0,1,0,1, each bit held 2 cycles.
  - serial_clock rises at k+2, k+4, …, k+16.
  - done pulses at k+17; a bench D-FF chain clocked by serial_clock holds 0xA5.
- LSB-first word (LSB_FIRST=1, DIV=4): load 0x0F. Required: bits 1,1,1,1,0,0,0,0, each held 4 cycles; frame high 32 cycles; exactly 8 clock rising edges.
- Busy reject: during a frame of 0x3C, drive load_valid=1 with data 0xFF for 5 cycles. Required: the 0x3C frame is unchanged and 0xFF is never transmitted.
- Back-to-back: hold load_valid with 0x81 then 0x7E. Required: the second frame's frame signal rises exactly WIDTH*DIV+2 cycles after the first accept.
- Mid-frame reset: assert reset at the 3rd bit of 0xC3. Required: all outputs cleared at that edge with no done pulse, and load_ready=1 afterwards.

Source files
------------

// File: rtl/dff_serial_tx.sv
// Parallel-in, serial-out transmitter driving the D and clock inputs of a
// downstream flip-flop chain; the bit clock rises mid-bit so sampled data is stable.
module dff_serial_tx #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 2,
  parameter int LSB_FIRST = 0
) (
  input  logic             input_clock1_1,
  input  logic             input_reset_2,
  input  logic             input_load_valid_3,
  input  logic [WIDTH-1:0] input_load_data_4,
  output logic             output_load_ready_5,
  output logic             output_serial_data_6,
  output logic             output_serial_clock_7,
  output logic             output_frame_8,
  output logic             output_done_9
);

  localparam int CW = $clog2(DIV);
  localparam int BW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]    div_cnt_q, div_cnt_d;
  logic             ser_data_q, ser_data_d;
  logic             ser_clk_q, ser_clk_d;
  logic             frame_q, frame_d;
  logic             done_q, done_d;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? {1'b0, w[WIDTH-1:1]} : {w[WIDTH-2:0], 1'b0};
  endfunction

  // Next-state logic; outputs are derived from the next state so they can be registered.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    case (state_q)
      IDLE: begin
        if (input_load_valid_3) begin
          shift_d   = input_load_data_4;
          bit_cnt_d = BW'(WIDTH - 1);
          div_cnt_d = {CW{1'b0}};
          state_d   = SHIFT;
        end else begin
          state_d   = IDLE;
        end
      end
      SHIFT: begin
        if (div_cnt_q == CW'(DIV - 1)) begin
          div_cnt_d = {CW{1'b0}};
          if (bit_cnt_q != {BW{1'b0}}) begin
            shift_d   = advance(shift_q);
            bit_cnt_d = bit_cnt_q - BW'(1);
          end else begin
            state_d   = DONE;
          end
        end else begin
          div_cnt_d = div_cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    frame_d    = (state_d == SHIFT);
    ser_clk_d  = (state_d == SHIFT) && (div_cnt_d >= CW'(DIV / 2));
    ser_data_d = (state_d == SHIFT) ? head_bit(shift_d) : 1'b0;
    done_d     = (state_d == DONE);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge input_clock1_1) begin
    if (input_reset_2) begin
      state_q    <= IDLE;
      shift_q    <= {WIDTH{1'b0}};
      bit_cnt_q  <= {BW{1'b0}};
      div_cnt_q  <= {CW{1'b0}};
      ser_data_q <= 1'b0;
      ser_clk_q  <= 1'b0;
      frame_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      div_cnt_q  <= div_cnt_d;
      ser_data_q <= ser_data_d;
      ser_clk_q  <= ser_clk_d;
      frame_q    <= frame_d;
      done_q     <= done_d;
    end
  end

  assign output_load_ready_5   = (state_q == IDLE);
  assign output_serial_data_6  = ser_data_q;
  assign output_serial_clock_7 = ser_clk_q;
  assign output_frame_8        = frame_q;
  assign output_done_9         = done_q;

endmodule

// File: tb/tb_dff_serial_tx.sv
// Self-checking bench: two transmitters (MSB-first DIV=2, LSB-first DIV=4)
// compared every cycle against a frame-position model plus directed literal checks.
module tb_dff_serial_tx;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1, valid_a = 1'b0;
  logic [7:0] data_a = 8'h00;
  logic       rst_b = 1'b1, valid_b = 1'b0;
  logic [7:0] data_b = 8'h00;
  logic       ready_a, sdat_a, sclk_a, frame_a, done_a;
  logic       ready_b, sdat_b, sclk_b, frame_b, done_b;

  int total = 0, passed = 0, cyc = 0;
  bit chk_en = 1'b0;

  // model: t = cycles since accept (0 = idle)
  int ta = 0, tb_t = 0;
  logic [7:0] wa = 8'h00, wb = 8'h00;

  logic [7:0] chain_a, chain_b;
  int rise_b = 0;

  always #5 clk = ~clk;

  dff_serial_tx #(.WIDTH(8), .DIV(2), .LSB_FIRST(0)) dut_a (
    .input_clock1_1(clk), .input_reset_2(rst_a), .input_load_valid_3(valid_a),
    .input_load_data_4(data_a), .output_load_ready_5(ready_a),
    .output_serial_data_6(sdat_a), .output_serial_clock_7(sclk_a),
    .output_frame_8(frame_a), .output_done_9(done_a));

  dff_serial_tx #(.WIDTH(8), .DIV(4), .LSB_FIRST(1)) dut_b (
    .input_clock1_1(clk), .input_reset_2(rst_b), .input_load_valid_3(valid_b),
    .input_load_data_4(data_b), .output_load_ready_5(ready_b),
    .output_serial_data_6(sdat_b), .output_serial_clock_7(sclk_b),
    .output_frame_8(frame_b), .output_done_9(done_b));

  // receiver flip-flop chains
  always @(posedge sclk_a) chain_a <= {chain_a[6:0], sdat_a};
  always @(posedge sclk_b) chain_b <= {sdat_b, chain_b[7:1]};
  always @(posedge sclk_b) rise_b <= rise_b + 1;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // {ready, frame, done, sclk, sdat} for position t in a frame of 8 bits
  function automatic logic [4:0] expect_out(input int t, input logic [7:0] w,
                                            input int div, input bit lsb);
    logic [4:0] e;
    int idx;
    e = 5'b00000;
    if (t == 0) e[4] = 1'b1;
    else if (t <= 8 * div) begin
      idx  = (t - 1) / div;
      e[3] = 1'b1;
      e[1] = (((t - 1) % div) >= div / 2);
      e[0] = lsb ? w[idx] : w[7 - idx];
    end else if (t == 8 * div + 1) e[2] = 1'b1;
    return e;
  endfunction

  // model advance at each clock edge
  always @(posedge clk) begin
    if (rst_a) ta <= 0;
    else if (ta == 0) begin
      if (valid_a) begin ta <= 1; wa <= data_a; end
    end else if (ta == 17) ta <= 0;
    else ta <= ta + 1;

    if (rst_b) tb_t <= 0;
    else if (tb_t == 0) begin
      if (valid_b) begin tb_t <= 1; wb <= data_b; end
    end else if (tb_t == 33) tb_t <= 0;
    else tb_t <= tb_t + 1;
  end

  // per-cycle comparison of both DUTs against the model
  always @(negedge clk) begin
    logic [4:0] ea, eb;
    if (chk_en) begin
      ea = expect_out(ta, wa, 2, 1'b0);
      eb = expect_out(tb_t, wb, 4, 1'b1);
      chk("a_ready", ready_a, ea[4]);
      chk("a_frame", frame_a, ea[3]);
      chk("a_done",  done_a,  ea[2]);
      chk("a_sclk",  sclk_a,  ea[1]);
      chk("a_sdat",  sdat_a,  ea[0]);
      chk("b_ready", ready_b, eb[4]);
      chk("b_frame", frame_b, eb[3]);
      chk("b_done",  done_b,  eb[2]);
      chk("b_sclk",  sclk_b,  eb[1]);
      chk("b_sdat",  sdat_b,  eb[0]);
    end
  end

  initial begin
    logic [15:0] dv, cv;
    logic [31:0] dv32;
    logic [7:0]  word1;
    int fcnt, rb0, f1, f2;
    bit got;

    // reset for two edges, then idle for ten cycles
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_ready", {ready_a, ready_b}, 2'b11);
      chk("rst_outs", {sdat_a, sclk_a, frame_a, done_a, sdat_b, sclk_b, frame_b, done_b}, 8'h00);
    end

    // MSB-first 0xA5, DIV=2
    valid_a = 1'b1; data_a = 8'hA5;
    @(negedge clk);
    valid_a = 1'b0; data_a = 8'h5A;
    dv = 16'h0; cv = 16'h0; fcnt = 0;
    for (int t = 1; t <= 16; t++) begin
      dv = {dv[14:0], sdat_a};
      cv = {cv[14:0], sclk_a};
      fcnt += frame_a;
      @(negedge clk);
    end
    chk("a5_data_seq", dv, 16'hCC33);
    chk("a5_clk_seq", cv, 16'h5555);
    chk("a5_frame_len", fcnt, 16);
    chk("a5_done", done_a, 1'b1);
    chk("a5_chain", chain_a, 8'hA5);
    @(negedge clk);
    chk("a5_ready_again", ready_a, 1'b1);

    // LSB-first 0x0F, DIV=4
    rb0 = rise_b;
    valid_b = 1'b1; data_b = 8'h0F;
    @(negedge clk);
    valid_b = 1'b0; data_b = 8'hF0;
    dv32 = 32'h0; fcnt = 0;
    for (int t = 1; t <= 32; t++) begin
      dv32 = {dv32[30:0], sdat_b};
      fcnt += frame_b;
      @(negedge clk);
    end
    chk("0f_data_seq", dv32, 32'hFFFF0000);
    chk("0f_frame_len", fcnt, 32);
    chk("0f_rises", rise_b - rb0, 8);
    chk("0f_done", done_b, 1'b1);
    chk("0f_chain", chain_b, 8'h0F);
    @(negedge clk);

    // busy reject: 0xFF offered while 0x3C is in flight
    valid_a = 1'b1; data_a = 8'h3C;
    @(negedge clk);
    valid_a = 1'b0;
    for (int t = 1; t <= 16; t++) begin
      if (t >= 3 && t <= 7) begin valid_a = 1'b1; data_a = 8'hFF; end
      else valid_a = 1'b0;
      @(negedge clk);
    end
    chk("busy_done", done_a, 1'b1);
    chk("busy_chain", chain_a, 8'h3C);
    fcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      fcnt += frame_a;
    end
    chk("busy_no_ff_frame", fcnt, 0);

    // back-to-back 0x81 then 0x7E with valid held
    valid_a = 1'b1; data_a = 8'h81;
    @(negedge clk);
    f1 = cyc;
    data_a = 8'h7E;
    word1 = 8'h00; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_a) word1 = chain_a;
      if (ready_a) begin got = 1'b1; break; end
    end
    chk("b2b_ready_seen", got, 1'b1);
    chk("b2b_word1", word1, 8'h81);
    @(negedge clk);
    valid_a = 1'b0;
    f2 = cyc;
    chk("b2b_frame2", frame_a, 1'b1);
    chk("b2b_spacing", f2 - f1, 18);
    for (int t = 1; t <= 16; t++) @(negedge clk);
    chk("b2b_done2", done_a, 1'b1);
    chk("b2b_word2", chain_a, 8'h7E);
    @(negedge clk);

    // mid-frame reset during third bit of 0xC3
    valid_a = 1'b1; data_a = 8'hC3;
    @(negedge clk);
    valid_a = 1'b0;
    for (int t = 1; t < 5; t++) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    chk("mrst_outs", {sdat_a, sclk_a, frame_a, done_a}, 4'h0);
    chk("mrst_ready", ready_a, 1'b1);
    fcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      fcnt += done_a + frame_a;
    end
    chk("mrst_no_done", fcnt, 0);

    // reset and load_valid together: nothing captured
    rst_a = 1'b1; valid_a = 1'b1; data_a = 8'h99;
    @(negedge clk);
    rst_a = 1'b0; valid_a = 1'b0;
    @(negedge clk);
    chk("rst_wins", {frame_a, ready_a}, 2'b01);
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
